// File: rtl/jk_bank_driver_if.sv
// Command, feedback and excitation bundle between jk_bank_driver and its environment.
// The DUT binds to the slave modport; the commander and bank model bind to master.
interface jk_bank_driver_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic [WIDTH-1:0] target;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, q_fb,
        input  cmd_ready, J, K, target, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, q_fb,
        output cmd_ready, J, K, target, done, err
    );
endinterface

// File: rtl/jk_bank_driver.sv
// J/K excitation driver for an external JK bank with Q-feedback verify and bounded retry.
// Latency: done one posedge after the accept edge on a correct bank; each retry adds one cycle.
// Backpressure: cmd_ready low outside IDLE and during the done cycle; JK_TOGGLE_EN selects toggle excitation.
module jk_bank_driver #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                 CLK,
    input  logic                 reset,
    jk_bank_driver_if.slave      bus
);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_INCR  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic [RW-1:0]    retry_cnt, retry_d;
    logic [WIDTH-1:0] new_tgt;

    function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] base,
                                                  input logic [WIDTH-1:0] tgt);
`ifdef JK_TOGGLE_EN
        return base ^ tgt;
`else
        return ~base & tgt;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] base,
                                                  input logic [WIDTH-1:0] tgt);
`ifdef JK_TOGGLE_EN
        return base ^ tgt;
`else
        return base & ~tgt;
`endif
    endfunction

    always_comb begin
        new_tgt = bus.q_fb;
        case (bus.cmd_op)
            OP_HOLD:  new_tgt = bus.q_fb;
            OP_LOAD:  new_tgt = bus.cmd_data;
            OP_INCR:  new_tgt = bus.q_fb + WIDTH'(1);
            OP_CLEAR: new_tgt = '0;
            default:  new_tgt = bus.q_fb;
        endcase
    end

    always_comb begin
        state_d  = state;
        j_d      = '0;
        k_d      = '0;
        target_d = target_q;
        done_d   = 1'b0;
        err_d    = err_q;
        retry_d  = retry_cnt;
        case (state)
            IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    target_d = new_tgt;
                    j_d      = excite_j(bus.q_fb, new_tgt);
                    k_d      = excite_k(bus.q_fb, new_tgt);
                    retry_d  = '0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                // The bank has already taken this cycle's J/K at the intervening negedge.
                if (bus.q_fb == target_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    retry_d = '0;
                end else if (retry_cnt < RETRY_MAX) begin
                    j_d     = excite_j(bus.q_fb, target_q);
                    k_d     = excite_k(bus.q_fb, target_q);
                    retry_d = retry_cnt + RW'(1);
                end else begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE) && !done_d;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            j_q       <= '0;
            k_q       <= '0;
            target_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            retry_cnt <= '0;
        end else begin
            state     <= state_d;
            j_q       <= j_d;
            k_q       <= k_d;
            target_q  <= target_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            retry_cnt <= retry_d;
        end
    end

    assign bus.J         = j_q;
    assign bus.K         = k_q;
    assign bus.target    = target_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.cmd_ready = ready_q;
endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver with a negedge JK bank model and optional stuck-at-0 bits.
module tb_jk_bank_driver;
    localparam int W = 4;

    logic CLK;
    logic reset;
    logic [W-1:0] bank;
    logic [W-1:0] stuck0;
    logic         preset_vld;
    logic [W-1:0] preset_val;
    int checks;
    int errors;

    jk_bank_driver_if #(.WIDTH(W)) bus ();

    jk_bank_driver #(.WIDTH(W), .MAX_RETRY(3)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.q_fb = bank;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // JK cell bank: set, reset, toggle, hold; stuck bits never read 1.
    always @(negedge CLK) begin
        if (preset_vld)
            bank <= preset_val & ~stuck0;
        else
            bank <= ((bus.J & ~bank) | (~bus.K & bank)) & ~stuck0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_bank(input logic [W-1:0] v);
        preset_val = v;
        preset_vld = 1'b1;
        @(negedge CLK);
        #1;
        preset_vld = 1'b0;
        tick();
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    logic [W-1:0] exp_j, exp_k;
    logic [8:0]   exp_done_seq, exp_ready_seq;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        stuck0 = '0;
        preset_vld = 1'b1;
        preset_val = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.cmd_data = '0;

        #1;
        check_eq("rst_j", bus.J, 0);
        check_eq("rst_k", bus.K, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_err", bus.err, 0);
        check_eq("rst_target", bus.target, 0);
        check_eq("rst_ready", bus.cmd_ready, 0);
        tick();
        tick();
        preset_vld = 1'b0;
        reset = 1'b1;
        check_eq("ready_before_edge", bus.cmd_ready, 0);
        tick();
        check_eq("ready_after_release", bus.cmd_ready, 1);

        // LOAD 1100 onto 0101
        set_bank(4'b0101);
        issue(2'b01, 4'b1100);
`ifdef JK_TOGGLE_EN
        exp_j = 4'b1001; exp_k = 4'b1001;
`else
        exp_j = 4'b1000; exp_k = 4'b0001;
`endif
        check_eq("load_j", bus.J, exp_j);
        check_eq("load_k", bus.K, exp_k);
        check_eq("load_target", bus.target, 4'b1100);
        check_eq("load_ready_busy", bus.cmd_ready, 0);
        check_eq("load_done_early", bus.done, 0);
        tick();
        check_eq("load_done", bus.done, 1);
        check_eq("load_bank", bank, 4'b1100);
        check_eq("load_j_idle", bus.J, 0);
        check_eq("load_ready_done", bus.cmd_ready, 0);
        tick();
        check_eq("load_done_pulse", bus.done, 0);
        check_eq("load_ready_back", bus.cmd_ready, 1);

        // INCR wraps 1111 -> 0000
        set_bank(4'b1111);
        issue(2'b10, 4'b1010);
`ifdef JK_TOGGLE_EN
        exp_j = 4'b1111; exp_k = 4'b1111;
`else
        exp_j = 4'b0000; exp_k = 4'b1111;
`endif
        check_eq("incr_target", bus.target, 4'b0000);
        check_eq("incr_j", bus.J, exp_j);
        check_eq("incr_k", bus.K, exp_k);
        tick();
        check_eq("incr_done", bus.done, 1);
        check_eq("incr_bank", bank, 4'b0000);
        tick();

        // HOLD drives nothing and still completes
        set_bank(4'b0110);
        issue(2'b00, 4'b1111);
        check_eq("hold_target", bus.target, 4'b0110);
        check_eq("hold_jk", {bus.J, bus.K}, 8'h00);
        tick();
        check_eq("hold_done", bus.done, 1);
        check_eq("hold_bank", bank, 4'b0110);
        tick();

        // Stuck-at-0 bit 2: four drives, then ERROR
        set_bank(4'b0000);
        stuck0 = 4'b0100;
        issue(2'b01, 4'b0100);
        check_eq("stuck_drive0_j", bus.J, 4'b0100);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_eq($sformatf("stuck_redrive%0d_j", i), bus.J, 4'b0100);
            check_eq($sformatf("stuck_redrive%0d_done", i), bus.done, 0);
        end
        tick();
        check_eq("stuck_err", bus.err, 1);
        check_eq("stuck_ready", bus.cmd_ready, 0);
        check_eq("stuck_jk", {bus.J, bus.K}, 8'h00);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 2'b11;
        for (int i = 0; i < 4; i++) tick();
        bus.cmd_valid = 1'b0;
        check_eq("error_sticky_err", bus.err, 1);
        check_eq("error_sticky_ready", bus.cmd_ready, 0);
        check_eq("error_sticky_jk", {bus.J, bus.K, bus.done}, 9'h000);

        reset = 1'b0;
        #1;
        check_eq("err_cleared", bus.err, 0);
        stuck0 = '0;
        tick();
        reset = 1'b1;
        tick();
        check_eq("ready_after_err_reset", bus.cmd_ready, 1);

        // Async reset while in DRIVE
        set_bank(4'b0000);
        issue(2'b01, 4'b1010);
        check_eq("mid_j_before", bus.J, 4'b1010);
        #1;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_jk", {bus.J, bus.K}, 8'h00);
        check_eq("mid_rst_target", bus.target, 0);
        check_eq("mid_rst_flags", {bus.done, bus.err, bus.cmd_ready}, 3'b000);
        tick();
        reset = 1'b1;
        check_eq("mid_rst_ready_low", bus.cmd_ready, 0);
        tick();
        check_eq("mid_rst_ready_high", bus.cmd_ready, 1);

        // Continuous CLEAR on 0011: accept, done, ready, repeating
        set_bank(4'b0011);
`ifdef JK_TOGGLE_EN
        exp_j = 4'b0011; exp_k = 4'b0011;
`else
        exp_j = 4'b0000; exp_k = 4'b0011;
`endif
        exp_done_seq  = 9'b010_010_010;
        exp_ready_seq = 9'b001_001_001;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 2'b11;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_eq($sformatf("clr_done_t%0d", i), bus.done, exp_done_seq[8-i]);
            check_eq($sformatf("clr_ready_t%0d", i), bus.cmd_ready, exp_ready_seq[8-i]);
            if (i == 0) begin
                check_eq("clr_first_j", bus.J, exp_j);
                check_eq("clr_first_k", bus.K, exp_k);
            end else if (i == 3) begin
                check_eq("clr_later_jk", {bus.J, bus.K}, 8'h00);
            end
        end
        bus.cmd_valid = 1'b0;
        check_eq("clr_bank", bank, 4'b0000);
        check_eq("clr_target", bus.target, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
